// File: rtl/layer1_pkg.sv
// layer1_pkg: bank state encoding and bank count shared by the ping-pong controller
package layer1_pkg;
   typedef enum logic [1:0] {FREE, WRITING, FULL, READING} bank_state_t;
   localparam int N_BANKS = 2;
endpackage

// File: rtl/layer1_bank_fsm.sv
// layer1_bank_fsm: lifecycle of one buffer bank (FREE -> WRITING -> FULL -> READING -> FREE)
module layer1_bank_fsm
   import layer1_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_wr,
   input  logic        end_wr,
   input  logic        start_rd,
   input  logic        end_rd,
   output bank_state_t state
);
   // each request is only raised by the top when the bank is in the matching state
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)        state <= FREE;
      else if (start_wr) state <= WRITING;
      else if (end_wr)   state <= FULL;
      else if (start_rd) state <= READING;
      else if (end_rd)   state <= FREE;
endmodule

// File: rtl/layer1_pingpong_ctrl.sv
// layer1_pingpong_ctrl: two-bank ping-pong buffer arbiter between one writer and one reader
module layer1_pingpong_ctrl
   import layer1_pkg::*;
#(
   parameter int N_TILES = 4,
   parameter int CNT_W   = 16
)(
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             wr_req,
   output logic             wr_gnt,
   output logic             wr_bank,
   input  logic             wr_done,
   output logic             rd_vld,
   output logic             rd_bank,
   input  logic             rd_ack,
   input  logic             rd_done,
   output logic             frame_done,
   output logic [CNT_W-1:0] tile_cnt,
   output logic [1:0]       full_cnt,
   output logic             err,
   input  logic             err_clr
);
   bank_state_t st [N_BANKS];
   logic wr_ptr, rd_ptr, rst_done;
   logic any_writing, do_gnt, do_full, do_ack, do_free, wr_bad, rd_bad, last_tile;
   // only the bank at wr_ptr can be WRITING and only the bank at rd_ptr can be READING
   assign any_writing = (st[0] == WRITING) || (st[1] == WRITING);
   assign do_gnt      = rst_done && wr_req && !wr_gnt && !any_writing && (st[wr_ptr] == FREE);
   assign do_full     = wr_done && any_writing;
   assign wr_bad      = wr_done && !any_writing;
   assign do_free     = rd_done && (st[rd_ptr] == READING);
   assign rd_bad      = rd_done && !do_free;
   assign rd_vld      = st[rd_ptr] == FULL;
   assign do_ack      = rd_vld && rd_ack;
   assign last_tile   = tile_cnt == CNT_W'(N_TILES - 1);
   assign wr_bank     = wr_ptr;
   assign rd_bank     = rd_ptr;
   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      layer1_bank_fsm u_bank (
         .clk      (ap_clk),
         .rst_n    (ap_rst_n),
         .start_wr (do_gnt  && wr_ptr == 1'(b)),
         .end_wr   (do_full && wr_ptr == 1'(b)),
         .start_rd (do_ack  && rd_ptr == 1'(b)),
         .end_rd   (do_free && rd_ptr == 1'(b)),
         .state    (st[b])
      );
   end
   // grant pulse; rst_done blocks a grant on the first edge after reset release
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         rst_done <= 1'b0;
         wr_gnt   <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         wr_gnt   <= do_gnt;
      end
   // bank pointers follow fill order; tile counter wraps at the end of each frame
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         tile_cnt   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= do_free && last_tile;
         if (do_full) wr_ptr <= ~wr_ptr;
         if (do_free) begin
            rd_ptr   <= ~rd_ptr;
            tile_cnt <= last_tile ? '0 : tile_cnt + CNT_W'(1);
         end
      end
   // FULL-bank count tracks fills in and reader acceptances out; sticky error with set over clear
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         full_cnt <= 2'd0;
         err      <= 1'b0;
      end else begin
         full_cnt <= full_cnt + 2'(do_full) - 2'(do_ack);
         err      <= wr_bad || rd_bad || (err && !err_clr);
      end
endmodule

// File: tb/tb_layer1_pingpong_ctrl.sv
// tb_layer1_pingpong_ctrl: directed vector table, reset corner cases and a randomized run against a bank-queue model
module tb_layer1_pingpong_ctrl;
   localparam int N_TILES = 4;
   typedef struct {
      logic [4:0]  in;
      logic [23:0] exp;
   } vec_t;
   logic        ap_clk = 1'b0, ap_rst_n = 1'b0;
   logic        wr_req = 1'b0, wr_done = 1'b0, rd_ack = 1'b0, rd_done = 1'b0, err_clr = 1'b0;
   logic        wr_gnt, wr_bank, rd_vld, rd_bank, frame_done, err;
   logic [15:0] tile_cnt;
   logic [1:0]  full_cnt;
   int          n_cmp = 0, n_bad = 0;
   vec_t        tbl[$];
   int          m_wr, m_rd, fills, reads, tiles;
   int          fq[$];
   bit          m_rdy, m_gnt, m_fd, m_err;

   always #5 ap_clk = ~ap_clk;

   layer1_pingpong_ctrl #(.N_TILES(N_TILES), .CNT_W(16)) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .wr_req     (wr_req),
      .wr_gnt     (wr_gnt),
      .wr_bank    (wr_bank),
      .wr_done    (wr_done),
      .rd_vld     (rd_vld),
      .rd_bank    (rd_bank),
      .rd_ack     (rd_ack),
      .rd_done    (rd_done),
      .frame_done (frame_done),
      .tile_cnt   (tile_cnt),
      .full_cnt   (full_cnt),
      .err        (err),
      .err_clr    (err_clr)
   );

   function automatic logic [23:0] mk(bit g, bit wb, bit v, bit rb, bit fd, int tc, int fc, bit e);
      return {g, wb, v, rb, fd, 16'(tc), 2'(fc), e};
   endfunction

   function automatic logic [23:0] act();
      return {wr_gnt, wr_bank, rd_vld, rd_bank, frame_done, tile_cnt, full_cnt, err};
   endfunction

   task automatic add(input logic [4:0] in, input logic [23:0] exp);
      vec_t v;
      v.in  = in;
      v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [4:0] in);
      {wr_req, wr_done, rd_ack, rd_done, err_clr} = in;
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [23:0] exp);
      logic [23:0] a;
      a = act();
      n_cmp++;
      if (a !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (gnt,wb,vld,rb,fd,tile_cnt,full_cnt,err)", nm, a, exp);
      end
   endtask

   // model: a bank is free unless it is being written, is queued full, or is being read
   function automatic bit bank_free(int b);
      if (b == m_wr || b == m_rd) return 0;
      foreach (fq[i]) if (fq[i] == b) return 0;
      return 1;
   endfunction

   task automatic model_reset();
      m_wr = -1; m_rd = -1; fills = 0; reads = 0; tiles = 0;
      fq.delete();
      m_rdy = 0; m_gnt = 0; m_fd = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [4:0] in);
      bit g, wok, rok, ack, es;
      g   = m_rdy && in[4] && m_wr < 0 && bank_free(fills % 2) && !m_gnt;
      wok = in[3] && m_wr >= 0;
      rok = in[1] && m_rd >= 0;
      ack = in[2] && m_rd < 0 && fq.size() > 0;
      es  = (in[3] && !wok) || (in[1] && !rok);
      m_fd = 0;
      if (wok) begin
         fq.push_back(m_wr);
         m_wr = -1;
         fills++;
      end
      if (rok) begin
         m_rd = -1;
         reads++;
         m_fd  = tiles == N_TILES - 1;
         tiles = m_fd ? 0 : tiles + 1;
      end
      if (ack) m_rd = fq.pop_front();
      if (g) m_wr = fills % 2;
      m_err = es ? 1'b1 : (in[0] ? 1'b0 : m_err);
      m_gnt = g;
      m_rdy = 1;
   endtask

   function automatic logic [23:0] model_exp();
      return mk(m_gnt, (fills % 2) == 1, m_rd < 0 && fq.size() > 0, (reads % 2) == 1, m_fd, tiles, fq.size(), m_err);
   endfunction

   initial begin
      // inputs: {wr_req, wr_done, rd_ack, rd_done, err_clr}
      add(5'b10000, mk(0,0,0,0,0,0,0,0));
      add(5'b10000, mk(1,0,0,0,0,0,0,0));
      add(5'b10000, mk(0,0,0,0,0,0,0,0));
      add(5'b01000, mk(0,1,1,0,0,0,1,0));
      add(5'b10000, mk(1,1,1,0,0,0,1,0));
      add(5'b11000, mk(0,0,1,0,0,0,2,0));
      add(5'b10000, mk(0,0,1,0,0,0,2,0));
      add(5'b10100, mk(0,0,0,0,0,0,1,0));
      add(5'b10100, mk(0,0,0,0,0,0,1,0));
      add(5'b10010, mk(0,0,1,1,0,1,1,0));
      add(5'b10000, mk(1,0,1,1,0,1,1,0));
      add(5'b00100, mk(0,0,0,1,0,1,0,0));
      add(5'b01010, mk(0,1,1,0,0,2,1,0));
      add(5'b01000, mk(0,1,1,0,0,2,1,1));
      add(5'b00000, mk(0,1,1,0,0,2,1,1));
      add(5'b00011, mk(0,1,1,0,0,2,1,1));
      add(5'b00001, mk(0,1,1,0,0,2,1,0));
      add(5'b00100, mk(0,1,0,0,0,2,0,0));
      add(5'b00010, mk(0,1,0,1,0,3,0,0));
      add(5'b10000, mk(1,1,0,1,0,3,0,0));
      add(5'b01000, mk(0,0,1,1,0,3,1,0));
      add(5'b00100, mk(0,0,0,1,0,3,0,0));
      add(5'b00010, mk(0,0,0,0,1,0,0,0));
      add(5'b00000, mk(0,0,0,0,0,0,0,0));
      tick();
      tick();
      check("reset_state", mk(0,0,0,0,0,0,0,0));
      ap_rst_n = 1'b1;
      foreach (tbl[i]) begin
         drive(tbl[i].in);
         tick();
         check($sformatf("row%0d", i), tbl[i].exp);
      end
      // fill both banks, reader takes bank 0, then reset lands mid-cycle
      drive(5'b10000); tick();
      drive(5'b01000); tick();
      drive(5'b10000); tick();
      drive(5'b01000); tick();
      drive(5'b00100); tick();
      drive(5'b00000);
      check("reading_and_full", mk(0,0,0,0,0,0,1,0));
      #2 ap_rst_n = 1'b0;
      #1 check("async_reset", mk(0,0,0,0,0,0,0,0));
      tick();
      check("reset_hold", mk(0,0,0,0,0,0,0,0));
      model_reset();
      ap_rst_n = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         logic [4:0] v;
         v[4] = 1'($urandom % 2);
         v[3] = (m_wr >= 0 && $urandom % 3 == 0) || $urandom % 40 == 0;
         v[2] = 1'($urandom % 2);
         v[1] = (m_rd >= 0 && $urandom % 3 == 0) || $urandom % 40 == 0;
         v[0] = $urandom % 8 == 0;
         drive(v);
         model_step(v);
         tick();
         check($sformatf("rand%0d", k), model_exp());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
